washer_plant_responder: RTL and testbench

- Sensor/actuator responder for the automatic washing machine controller. It sits on the controller's actuator outputs and produces the sensor inputs the controller consumes.
- Inputs are door lock, motor, fill valve, drain valve and detergent request. Outputs are filled, drained, detergent_added, cycle_timeout and spin_timeout.
- Serves as a synthesizable plant for closed-loop FPGA demos and as the reactive stimulus in controller benches.
- Also flags interlock and overflow faults.

---
 rtl/washer_plant_responder.sv | 179 +++++++++++++++++
 tb/tb_washer_plant_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/washer_plant_responder.sv
// Reactive washer plant: models tank level, detergent dispenser and wash/spin
// timers driven by the controller's actuator outputs, plus sticky fault flags.
module washer_plant_responder #(
    parameter int LEVEL_W     = 8,
    parameter int MAX_LEVEL   = 250,
    parameter int FULL_LEVEL  = 200,
    parameter int FILL_RATE   = 4,
    parameter int DRAIN_RATE  = 8,
    parameter int TICK_DIV    = 4,
    parameter int TIMER_W     = 16,
    parameter int DET_TICKS   = 16,
    parameter int CYCLE_TICKS = 100,
    parameter int SPIN_TICKS  = 50
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               door_lock,
    input  logic               motor_on,
    input  logic               fill_valve_on,
    input  logic               drain_valve_on,
    input  logic               detergent_req,
    output logic               filled,
    output logic               drained,
    output logic               detergent_added,
    output logic               cycle_timeout,
    output logic               spin_timeout,
    output logic [LEVEL_W-1:0] water_level,
    output logic               interlock_fault,
    output logic               overflow_fault
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Level arithmetic carries two extra bits so both underflow and overflow are visible.
    localparam logic signed [LEVEL_W+1:0] ZERO_S  = '0;
    localparam logic signed [LEVEL_W+1:0] FILL_S  = (LEVEL_W+2)'(FILL_RATE);
    localparam logic signed [LEVEL_W+1:0] DRAIN_S = (LEVEL_W+2)'(DRAIN_RATE);
    localparam logic signed [LEVEL_W+1:0] MAX_S   = (LEVEL_W+2)'(MAX_LEVEL);

    typedef enum logic [1:0] {
        DET_IDLE     = 2'd0,
        DET_DISPENSE = 2'd1,
        DET_DONE     = 2'd2
    } det_state_t;

    logic [LEVEL_W-1:0]        level_reg;
    logic [LEVEL_W-1:0]        level_next;
    logic signed [LEVEL_W+1:0] level_sum;
    logic [PRESC_W-1:0]        presc_reg;
    logic                      tick;
    det_state_t                det_state_reg;
    logic [TIMER_W-1:0]        det_cnt_reg;
    logic                      detergent_added_reg;
    logic                      interlock_fault_reg;
    logic                      overflow_fault_reg;
    logic [1:0]                timer_mode;
    logic [1:0]                timeout_vec;

    always_comb begin
        level_sum  = $signed({2'b00, level_reg})
                   + (fill_valve_on  ? FILL_S  : ZERO_S)
                   - (drain_valve_on ? DRAIN_S : ZERO_S);
        level_next = level_sum[LEVEL_W-1:0];
        if (level_sum < ZERO_S) begin
            level_next = '0;
        end else if (level_sum > MAX_S) begin
            level_next = LEVEL_W'(MAX_LEVEL);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_reg <= '0;
        end else begin
            level_reg <= level_next;
        end
    end

    assign tick = (presc_reg == PRESC_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            det_state_reg       <= DET_IDLE;
            det_cnt_reg         <= '0;
            detergent_added_reg <= 1'b0;
        end else begin
            case (det_state_reg)
                DET_IDLE: begin
                    detergent_added_reg <= 1'b0;
                    if (detergent_req) begin
                        det_state_reg <= DET_DISPENSE;
                        det_cnt_reg   <= '0;
                    end
                end
                DET_DISPENSE: begin
                    if (!detergent_req) begin
                        det_state_reg <= DET_IDLE;
                    end else if (tick) begin
                        det_cnt_reg <= det_cnt_reg + 1'b1;
                        if (det_cnt_reg + 1'b1 == TIMER_W'(DET_TICKS)) begin
                            det_state_reg       <= DET_DONE;
                            detergent_added_reg <= 1'b1;
                        end
                    end
                end
                DET_DONE: begin
                    if (!detergent_req) begin
                        det_state_reg       <= DET_IDLE;
                        detergent_added_reg <= 1'b0;
                    end
                end
                default: begin
                    det_state_reg       <= DET_IDLE;
                    detergent_added_reg <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            interlock_fault_reg <= 1'b0;
            overflow_fault_reg  <= 1'b0;
        end else begin
            if (!door_lock && (motor_on || fill_valve_on || drain_valve_on)) begin
                interlock_fault_reg <= 1'b1;
            end
            if ((level_reg == LEVEL_W'(MAX_LEVEL)) && fill_valve_on && !drain_valve_on) begin
                overflow_fault_reg <= 1'b1;
            end
        end
    end

    // Index 0 is the wash timer, index 1 the spin timer; the modes are exclusive.
    assign timer_mode[0] = motor_on & ~drain_valve_on;
    assign timer_mode[1] = motor_on &  drain_valve_on;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : timer_g
            localparam logic [TIMER_W-1:0] LIMIT =
                TIMER_W'((gi == 0) ? CYCLE_TICKS : SPIN_TICKS);

            logic [TIMER_W-1:0] cnt_reg;
            logic               timeout_reg;

            always_ff @(posedge clk) begin
                if (reset || !timer_mode[gi]) begin
                    cnt_reg     <= '0;
                    timeout_reg <= 1'b0;
                end else if (tick && !interlock_fault_reg && (cnt_reg != LIMIT)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg + 1'b1 == LIMIT) begin
                        timeout_reg <= 1'b1;
                    end
                end
            end

            assign timeout_vec[gi] = timeout_reg;
        end
    endgenerate

    assign water_level     = level_reg;
    assign filled          = (level_reg >= LEVEL_W'(FULL_LEVEL));
    assign drained         = (level_reg == '0);
    assign detergent_added = detergent_added_reg;
    assign cycle_timeout   = timeout_vec[0];
    assign spin_timeout    = timeout_vec[1];
    assign interlock_fault = interlock_fault_reg;
    assign overflow_fault  = overflow_fault_reg;

endmodule

// File: tb/tb_washer_plant_responder.sv
// Directed bench for washer_plant_responder with hand-computed expectations.
module tb_washer_plant_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       door_lock = 1'b0;
    logic       motor_on = 1'b0;
    logic       fill_valve_on = 1'b0;
    logic       drain_valve_on = 1'b0;
    logic       detergent_req = 1'b0;
    logic       filled;
    logic       drained;
    logic       detergent_added;
    logic       cycle_timeout;
    logic       spin_timeout;
    logic [7:0] water_level;
    logic       interlock_fault;
    logic       overflow_fault;

    int total = 0;
    int bad = 0;
    int seen_added;

    washer_plant_responder dut (
        .clk             (clk),
        .reset           (reset),
        .door_lock       (door_lock),
        .motor_on        (motor_on),
        .fill_valve_on   (fill_valve_on),
        .drain_valve_on  (drain_valve_on),
        .detergent_req   (detergent_req),
        .filled          (filled),
        .drained         (drained),
        .detergent_added (detergent_added),
        .cycle_timeout   (cycle_timeout),
        .spin_timeout    (spin_timeout),
        .water_level     (water_level),
        .interlock_fault (interlock_fault),
        .overflow_fault  (overflow_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        total++;
        if (obs !== exp_val) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_val);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Advance n clock edges; inputs/checks happen 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves reset released right after the edge that cleared the prescaler.
    task automatic restart();
        reset = 1'b1;
        door_lock = 1'b0;
        motor_on = 1'b0;
        fill_valve_on = 1'b0;
        drain_valve_on = 1'b0;
        detergent_req = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".level"}, 32'(water_level), 0);
        check({tag, ".drained"}, 32'(drained), 1);
        check({tag, ".filled"}, 32'(filled), 0);
        check({tag, ".det"}, 32'(detergent_added), 0);
        check({tag, ".cyc"}, 32'(cycle_timeout), 0);
        check({tag, ".spin"}, 32'(spin_timeout), 0);
        check({tag, ".ilk"}, 32'(interlock_fault), 0);
        check({tag, ".ovf"}, 32'(overflow_fault), 0);
    endtask

    initial begin
        restart();
        check_reset_state("rst");

        // Fill: +4 per clk, filled at 200, clamp at 250, overflow the cycle after.
        door_lock = 1'b1;
        fill_valve_on = 1'b1;
        step(49);
        check("fill49.level", 32'(water_level), 196);
        check("fill49.filled", 32'(filled), 0);
        step(1);
        check("fill50.level", 32'(water_level), 200);
        check("fill50.filled", 32'(filled), 1);
        step(12);
        check("fill62.level", 32'(water_level), 248);
        step(1);
        check("fill63.level", 32'(water_level), 250);
        check("fill63.ovf", 32'(overflow_fault), 0);
        step(1);
        check("fill64.level", 32'(water_level), 250);
        check("fill64.ovf", 32'(overflow_fault), 1);

        // Drain from 200 at -8 per clk, then both valves for a net -4.
        restart();
        door_lock = 1'b1;
        fill_valve_on = 1'b1;
        step(50);
        check("pre_drain.level", 32'(water_level), 200);
        fill_valve_on = 1'b0;
        drain_valve_on = 1'b1;
        step(24);
        check("drain24.level", 32'(water_level), 8);
        check("drain24.drained", 32'(drained), 0);
        step(1);
        check("drain25.level", 32'(water_level), 0);
        check("drain25.drained", 32'(drained), 1);
        step(1);
        check("drain_floor.level", 32'(water_level), 0);
        drain_valve_on = 1'b0;
        fill_valve_on = 1'b1;
        step(10);
        check("refill10.level", 32'(water_level), 40);
        drain_valve_on = 1'b1;
        step(1);
        check("both1.level", 32'(water_level), 36);
        step(4);
        check("both5.level", 32'(water_level), 20);

        // Detergent: 16th tick lands on edge 64 after release.
        restart();
        detergent_req = 1'b1;
        step(63);
        check("det63", 32'(detergent_added), 0);
        step(1);
        check("det64", 32'(detergent_added), 1);
        step(5);
        check("det_hold", 32'(detergent_added), 1);
        detergent_req = 1'b0;
        step(1);
        check("det_drop", 32'(detergent_added), 0);

        // Request withdrawn after 8 ticks: never asserts.
        restart();
        detergent_req = 1'b1;
        step(32);
        detergent_req = 1'b0;
        seen_added = 0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (detergent_added) seen_added++;
        end
        check("det_abort", 32'(seen_added), 0);

        // Wash: 100 ticks = 400 clks.
        restart();
        door_lock = 1'b1;
        motor_on = 1'b1;
        step(399);
        check("wash399", 32'(cycle_timeout), 0);
        step(1);
        check("wash400", 32'(cycle_timeout), 1);
        step(20);
        check("wash_hold", 32'(cycle_timeout), 1);
        motor_on = 1'b0;
        step(1);
        check("wash_clear", 32'(cycle_timeout), 0);

        // Spin: 50 ticks = 200 clks, wash timer stays idle.
        restart();
        door_lock = 1'b1;
        motor_on = 1'b1;
        drain_valve_on = 1'b1;
        step(199);
        check("spin199", 32'(spin_timeout), 0);
        step(1);
        check("spin200", 32'(spin_timeout), 1);
        check("spin.cyc", 32'(cycle_timeout), 0);

        // Interlock: one unlocked clk with motor on freezes the wash timer.
        restart();
        door_lock = 1'b1;
        motor_on = 1'b1;
        step(20);
        door_lock = 1'b0;
        step(1);
        door_lock = 1'b1;
        check("ilk.set", 32'(interlock_fault), 1);
        fill_valve_on = 1'b1;
        step(5);
        fill_valve_on = 1'b0;
        check("ilk.level", 32'(water_level), 20);
        step(500);
        check("ilk.sticky", 32'(interlock_fault), 1);
        check("ilk.frozen", 32'(cycle_timeout), 0);
        reset = 1'b1;
        step(1);
        check_reset_state("ilk_rst");
        reset = 1'b0;

        // Reset in the middle of dispensing, washing and filling.
        restart();
        door_lock = 1'b1;
        motor_on = 1'b1;
        fill_valve_on = 1'b1;
        detergent_req = 1'b1;
        step(30);
        check("mid.level", 32'(water_level), 120);
        reset = 1'b1;
        step(1);
        check_reset_state("mid_rst");
        reset = 1'b0;
        door_lock = 1'b0;
        motor_on = 1'b0;
        fill_valve_on = 1'b0;
        detergent_req = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
